writeback_unit: RTL and testbench

//  Writeback stage feeding the register file's rd/writedata/regwrite write port.

---
 rtl/writeback_unit_pkg.sv | 27 ++
 rtl/writeback_unit_if.sv | 43 ++++
 rtl/writeback_unit_wb_fifo.sv | 65 ++++++
 rtl/writeback_unit.sv | 103 ++++++++++
 tb/tb_writeback_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : writeback_unit_pkg
// Brief  : Shared widths, register-file constants and FIFO entry type for the
//          writeback stage.
// Rev    : 1.0
// ============================================================================
package writeback_unit_pkg;

    localparam int c_XLEN       = 32;
    localparam int c_REG_ADDR_W = 5;
    localparam int c_REG_COUNT  = 1 << c_REG_ADDR_W;
    localparam int c_FIFO_DEPTH = 4;

    localparam logic [c_REG_ADDR_W-1:0] c_X0 = '0;

    typedef struct packed {
        logic [c_REG_ADDR_W-1:0] rd;
        logic [c_XLEN-1:0]       data;
    } wb_entry_t;

    function automatic logic is_x0(input logic [c_REG_ADDR_W-1:0] r);
        return r == c_X0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_unit_if.sv
`default_nettype none
// ============================================================================
// Module : writeback_unit_if
// Brief  : Result handshakes, issue/hazard query and register-file write port
//          of the writeback stage.
// Rev    : 1.0
// ============================================================================
interface writeback_unit_if;
    import writeback_unit_pkg::*;

    logic                    alu_valid;
    logic [c_REG_ADDR_W-1:0] alu_rd;
    logic [c_XLEN-1:0]       alu_result;
    logic                    alu_ready;
    logic                    mem_valid;
    logic [c_REG_ADDR_W-1:0] mem_rd;
    logic [c_XLEN-1:0]       mem_data;
    logic                    mem_ready;
    logic                    issue_valid;
    logic [c_REG_ADDR_W-1:0] issue_rd;
    logic                    rf_stall;
    logic [c_REG_ADDR_W-1:0] rs1;
    logic [c_REG_ADDR_W-1:0] rs2;
    logic                    rs1_busy;
    logic                    rs2_busy;
    logic [c_REG_ADDR_W-1:0] rd;
    logic [c_XLEN-1:0]       writedata;
    logic                    regwrite;

    modport master (
        output alu_valid, alu_rd, alu_result, mem_valid, mem_rd, mem_data,
               issue_valid, issue_rd, rf_stall, rs1, rs2,
        input  alu_ready, mem_ready, rs1_busy, rs2_busy, rd, writedata, regwrite
    );

    modport slave (
        input  alu_valid, alu_rd, alu_result, mem_valid, mem_rd, mem_data,
               issue_valid, issue_rd, rf_stall, rs1, rs2,
        output alu_ready, mem_ready, rs1_busy, rs2_busy, rd, writedata, regwrite
    );

endinterface
`default_nettype wire

// File: rtl/writeback_unit_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module : wb_fifo
// Brief  : Parametric synchronous FIFO (power-of-two depth) with full/empty.
// Rev    : 1.0
// ============================================================================
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Guard here too so a misbehaving caller cannot corrupt the pointers.
    assign w_push     = i_push & ~o_full;
    assign w_pop      = i_pop & ~o_empty;
    assign o_full     = (r_count == c_FULL);
    assign o_empty    = (r_count == '0);
    assign o_pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module : writeback_unit
// Brief  : Merges ALU and load results into an in-order buffer, drives one
//          register-file write per cycle and tracks pending writes for RAW.
// Rev    : 1.0
// ============================================================================
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = c_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    writeback_unit_if.slave   bus
);

    logic                    w_full;
    logic                    w_empty;
    logic                    w_mem_fire;
    logic                    w_alu_fire;
    logic                    w_push;
    logic                    w_pop;
    wb_entry_t               w_push_entry;
    wb_entry_t               w_head;
    logic [c_REG_COUNT-1:0]  w_busy_next;

    logic [c_REG_COUNT-1:0]  r_busy;
    logic [c_REG_ADDR_W-1:0] r_rd;
    logic [c_XLEN-1:0]       r_writedata;
    logic                    r_regwrite;

    // Ready looks only at occupancy, never at a same-cycle pop; mem wins ties.
    assign bus.mem_ready = ~w_full;
    assign bus.alu_ready = ~w_full & ~bus.mem_valid;
    assign w_mem_fire    = bus.mem_valid & ~w_full;
    assign w_alu_fire    = bus.alu_valid & ~w_full & ~bus.mem_valid;

    // x0 results complete their handshake but are dropped here.
    assign w_push = (w_mem_fire & ~is_x0(bus.mem_rd)) |
                    (w_alu_fire & ~is_x0(bus.alu_rd));
    assign w_pop  = ~w_empty & ~bus.rf_stall;

    always_comb begin
        w_push_entry = '{rd: bus.alu_rd, data: bus.alu_result};
        if (w_mem_fire) begin
            w_push_entry = '{rd: bus.mem_rd, data: bus.mem_data};
        end
    end

    wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wb_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Clear before set so a same-edge issue to the popped register stays busy.
    always_comb begin
        w_busy_next = r_busy;
        if (w_pop) begin
            w_busy_next[w_head.rd] = 1'b0;
        end
        if (bus.issue_valid & ~is_x0(bus.issue_rd)) begin
            w_busy_next[bus.issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= '0;
            r_regwrite  <= 1'b0;
            r_rd        <= '0;
            r_writedata <= '0;
        end else begin
            r_busy     <= w_busy_next;
            r_regwrite <= w_pop;
            if (w_pop) begin
                r_rd        <= w_head.rd;
                r_writedata <= w_head.data;
            end
        end
    end

    assign bus.rd        = r_rd;
    assign bus.writedata = r_writedata;
    assign bus.regwrite  = r_regwrite;

    // The write in flight on the register-file port still counts as pending.
    assign bus.rs1_busy = ~is_x0(bus.rs1) &
                          (r_busy[bus.rs1] | (r_regwrite & (r_rd == bus.rs1)));
    assign bus.rs2_busy = ~is_x0(bus.rs2) &
                          (r_busy[bus.rs2] | (r_regwrite & (r_rd == bus.rs2)));

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_writeback_unit
// Brief  : Directed scenarios plus randomized traffic against a queue model.
// Rev    : 1.0
// ============================================================================
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    localparam int DEPTH = c_FIFO_DEPTH;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    writeback_unit_if wb();

    writeback_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (wb)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: pending results in acceptance order plus a pending set.
    wb_entry_t        mq[$];
    logic [31:0]      mbusy = '0;
    logic             m_rw  = 1'b0;
    logic [4:0]       m_rd  = '0;
    logic [31:0]      m_wd  = '0;

    function automatic logic exp_busy(input logic [4:0] r);
        return (r != 0) && (mbusy[r] || (m_rw && m_rd == r));
    endfunction

    task automatic idle();
        wb.alu_valid = 0; wb.alu_rd = 0; wb.alu_result = 0;
        wb.mem_valid = 0; wb.mem_rd = 0; wb.mem_data = 0;
        wb.issue_valid = 0; wb.issue_rd = 0; wb.rf_stall = 0;
        wb.rs1 = 0; wb.rs2 = 0;
    endtask

    // Advance one clock, updating the model from the inputs seen at that edge.
    task automatic step();
        wb_entry_t e;
        int n;
        n = mq.size();
        if (reset) begin
            mq.delete(); mbusy = '0; m_rw = 0; m_rd = '0; m_wd = '0;
        end else begin
            if (n > 0 && !wb.rf_stall) begin
                e = mq.pop_front();
                m_rw = 1; m_rd = e.rd; m_wd = e.data; mbusy[e.rd] = 1'b0;
            end else begin
                m_rw = 0;
            end
            if (wb.issue_valid && wb.issue_rd != 0) mbusy[wb.issue_rd] = 1'b1;
            if (n < DEPTH) begin
                if (wb.mem_valid) begin
                    if (wb.mem_rd != 0) mq.push_back('{rd: wb.mem_rd, data: wb.mem_data});
                end else if (wb.alu_valid && wb.alu_rd != 0) begin
                    mq.push_back('{rd: wb.alu_rd, data: wb.alu_result});
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle(); reset = 1; step(); step(); reset = 0;
        wb.rs1 = 5; #1;
        checks++; if (wb.regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", wb.regwrite); end
        checks++; if (wb.rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", wb.rd); end
        checks++; if (wb.writedata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %0h want 0", wb.writedata); end
        checks++; if (wb.mem_ready !== 1'b1 || wb.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got mem=%b alu=%b want 1/1", wb.mem_ready, wb.alu_ready); end
        checks++; if (wb.rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", wb.rs1_busy); end
        idle();
    endtask

    task automatic test_single();
        wb.alu_valid = 1; wb.alu_rd = 3; wb.alu_result = 7; #1;
        checks++; if (wb.alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", wb.alu_ready); end
        step(); idle();
        checks++; if (wb.regwrite !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", wb.regwrite); end
        step();
        checks++; if (wb.regwrite !== 1'b1 || wb.rd !== 5'd3 || wb.writedata !== 32'd7) begin errors++; $display("FAIL single_write: got rw=%b rd=%0d wd=%0h want 1/3/7", wb.regwrite, wb.rd, wb.writedata); end
        step();
        checks++; if (wb.regwrite !== 1'b0 || wb.rd !== 5'd3) begin errors++; $display("FAIL single_hold: got rw=%b rd=%0d want 0/3", wb.regwrite, wb.rd); end
    endtask

    task automatic test_arbitration();
        wb.alu_valid = 1; wb.alu_rd = 1; wb.alu_result = 32'h11;
        wb.mem_valid = 1; wb.mem_rd = 2; wb.mem_data = 32'h22; #1;
        checks++; if (wb.mem_ready !== 1'b1 || wb.alu_ready !== 1'b0) begin errors++; $display("FAIL arb_ready: got mem=%b alu=%b want 1/0", wb.mem_ready, wb.alu_ready); end
        step(); wb.mem_valid = 0; #1;
        checks++; if (wb.alu_ready !== 1'b1) begin errors++; $display("FAIL arb_alu_ready: got %b want 1", wb.alu_ready); end
        step(); idle();
        checks++; if (wb.regwrite !== 1'b1 || wb.rd !== 5'd2 || wb.writedata !== 32'h22) begin errors++; $display("FAIL arb_first: got rw=%b rd=%0d wd=%0h want 1/2/22", wb.regwrite, wb.rd, wb.writedata); end
        step();
        checks++; if (wb.regwrite !== 1'b1 || wb.rd !== 5'd1 || wb.writedata !== 32'h11) begin errors++; $display("FAIL arb_second: got rw=%b rd=%0d wd=%0h want 1/1/11", wb.regwrite, wb.rd, wb.writedata); end
        step();
    endtask

    task automatic test_stall();
        logic [4:0]  erd [DEPTH];
        logic [31:0] ewd [DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            erd[i] = 5'($urandom_range(1, 31)); ewd[i] = $urandom;
            wb.rf_stall = 1; wb.alu_valid = 1; wb.alu_rd = erd[i]; wb.alu_result = ewd[i];
            step();
        end
        wb.mem_valid = 1; wb.mem_rd = 9; #1;
        checks++; if (wb.alu_ready !== 1'b0 || wb.mem_ready !== 1'b0) begin errors++; $display("FAIL stall_full: got mem=%b alu=%b want 0/0", wb.mem_ready, wb.alu_ready); end
        checks++; if (wb.regwrite !== 1'b0) begin errors++; $display("FAIL stall_rw: got %b want 0", wb.regwrite); end
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            step();
            checks++; if (wb.regwrite !== 1'b1 || wb.rd !== erd[i] || wb.writedata !== ewd[i]) begin errors++; $display("FAIL stall_drain%0d: got rw=%b rd=%0d wd=%0h want 1/%0d/%0h", i, wb.regwrite, wb.rd, wb.writedata, erd[i], ewd[i]); end
        end
        step();
        checks++; if (wb.regwrite !== 1'b0) begin errors++; $display("FAIL stall_empty: got %b want 0", wb.regwrite); end
    endtask

    task automatic test_x0();
        wb.alu_valid = 1; wb.alu_rd = 0; wb.alu_result = 32'hFFFF; #1;
        checks++; if (wb.alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b want 1", wb.alu_ready); end
        step(); idle();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (wb.regwrite !== 1'b0) begin errors++; $display("FAIL x0_write%0d: got %b want 0", i, wb.regwrite); end
        end
    endtask

    task automatic test_scoreboard();
        wb.rs1 = 5; wb.rs2 = 0; wb.issue_valid = 1; wb.issue_rd = 5;
        step(); wb.issue_rd = 0;
        checks++; if (wb.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_issue: got %b want 1", wb.rs1_busy); end
        step(); wb.issue_valid = 0;
        checks++; if (wb.rs2_busy !== 1'b0) begin errors++; $display("FAIL sb_x0: got %b want 0", wb.rs2_busy); end
        wb.mem_valid = 1; wb.mem_rd = 5; wb.mem_data = 9;
        step(); wb.mem_valid = 0;
        checks++; if (wb.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_queued: got %b want 1", wb.rs1_busy); end
        step();
        checks++; if (wb.regwrite !== 1'b1 || wb.rd !== 5'd5 || wb.writedata !== 32'd9 || wb.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_pop: got rw=%b rd=%0d wd=%0h busy=%b want 1/5/9/1", wb.regwrite, wb.rd, wb.writedata, wb.rs1_busy); end
        step();
        checks++; if (wb.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_clear: got %b want 0", wb.rs1_busy); end
        idle();
    endtask

    task automatic test_reset_mid();
        wb.issue_valid = 1; wb.issue_rd = 6;
        for (int i = 0; i < 3; i++) begin
            wb.rf_stall = 1; wb.alu_valid = 1; wb.alu_rd = 5'(6 + i); wb.alu_result = $urandom;
            step(); wb.issue_valid = 0;
        end
        idle(); wb.rf_stall = 1; reset = 1; step(); reset = 0;
        idle(); wb.rs1 = 6; wb.rs2 = 7; #1;
        checks++; if (wb.regwrite !== 1'b0) begin errors++; $display("FAIL rst_mid_rw: got %b want 0", wb.regwrite); end
        checks++; if (wb.alu_ready !== 1'b1 || wb.mem_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got mem=%b alu=%b want 1/1", wb.mem_ready, wb.alu_ready); end
        checks++; if (wb.rs1_busy !== 1'b0 || wb.rs2_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b%b want 00", wb.rs1_busy, wb.rs2_busy); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (wb.regwrite !== 1'b0) begin errors++; $display("FAIL rst_mid_drain%0d: got %b want 0", i, wb.regwrite); end
        end
    endtask

    task automatic test_random();
        logic er;
        for (int i = 0; i < 400; i++) begin
            wb.alu_valid = 1'($urandom); wb.alu_rd = 5'($urandom_range(0, 3)); wb.alu_result = $urandom;
            wb.mem_valid = ($urandom_range(0, 2) == 0); wb.mem_rd = 5'($urandom_range(0, 3)); wb.mem_data = $urandom;
            wb.issue_valid = 1'($urandom); wb.issue_rd = 5'($urandom_range(0, 3));
            wb.rf_stall = ($urandom_range(0, 3) == 0);
            wb.rs1 = 5'($urandom_range(0, 3)); wb.rs2 = 5'($urandom_range(0, 3)); #1;
            er = (mq.size() < DEPTH);
            checks++; if (wb.mem_ready !== er || wb.alu_ready !== (er & ~wb.mem_valid)) begin errors++; $display("FAIL rnd_ready%0d: got mem=%b alu=%b want %b/%b", i, wb.mem_ready, wb.alu_ready, er, er & ~wb.mem_valid); end
            step();
            checks++; if (wb.regwrite !== m_rw || wb.rd !== m_rd || wb.writedata !== m_wd) begin errors++; $display("FAIL rnd_write%0d: got rw=%b rd=%0d wd=%0h want %b/%0d/%0h", i, wb.regwrite, wb.rd, wb.writedata, m_rw, m_rd, m_wd); end
            checks++; if (wb.rs1_busy !== exp_busy(wb.rs1) || wb.rs2_busy !== exp_busy(wb.rs2)) begin errors++; $display("FAIL rnd_busy%0d: got %b%b want %b%b", i, wb.rs1_busy, wb.rs2_busy, exp_busy(wb.rs1), exp_busy(wb.rs2)); end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_arbitration();
        test_stall();
        test_x0();
        test_scoreboard();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
